gol_display_scan: RTL and testbench
===================================

# gol_display_scan

Downstream consumer of the 8x8 Game of Life generator. Accepts each 64-bit generation over a valid/ready handshake and double-buffers it. Scans the current generation out row by row to a multiplexed 8x8 LED matrix. Also reports a generation count plus still-life and extinction flags for the board-level status LEDs.

## Interface
- ROW_HOLD, 4, clock cycles each row is driven (legal range 1..255)
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- grid_in  input  64  generation from the GoL core; row r = grid_in[63-8r -: 8], bit 7 of a row = leftmost cell
- grid_valid  input  1  grid_in holds a new generation
- grid_ready  output  1  block can accept; transfer occurs on a rising edge with grid_valid && grid_ready
- row_sel  output  8  one-hot row drive, bit r = row r; all zero when not scanning
- col_data  output  8  column data for the selected row (1 = cell alive)
- frame_done  output  1  one-cycle pulse at the end of each scanned frame
- gen_count  output  16  number of accepted generations, saturating at 16'hFFFF
- still_life  output  1  last accepted grid equals the one before it
- extinct  output  1  last accepted grid is all zero

## Operation
- Storage:
  - shadow[63:0] holds the last accepted grid.
  - pending flag is set when shadow holds a grid not yet shown.
  - active[63:0] holds the grid being scanned.
- grid_ready = !pending (combinational).
- Accept edge (grid_valid && grid_ready):
  - shadow <= grid_in, pending <= 1.
  - gen_count <= gen_count+1, saturating.
  - extinct <= (grid_in == 0).
  - still_life <= (gen_count != 0) && (grid_in == shadow), compared against the old shadow.
- FSM states IDLE and SCAN.
  - IDLE: row_sel = 0, col_data = 0. If pending: active <= shadow, pending <= 0, row <= 0, hold <= 0, go to SCAN.
  - SCAN: row_sel = 1 << row, col_data = active[63-8*row -: 8].
    - hold counts 0..ROW_HOLD-1. On wrap, row increments.
    - At row 7 with hold = ROW_HOLD-1 (frame end): frame_done <= 1 next cycle. row <= 0. If pending: active <= shadow, pending <= 0; otherwise the same active grid is rescanned.
    - SCAN never returns to IDLE except by reset.
- The active buffer changes only at a frame boundary, so no torn frames.
- row_sel and col_data are registered, derived from registered state.
- Simultaneous frame-end swap and a grid_valid: grid_ready is low that cycle because pending = 1, so no accept. grid_ready rises the next cycle.

## Timing
- Reset, asynchronous:
  - Outputs: row_sel = 0, col_data = 0, frame_done = 0, gen_count = 0, still_life = 0, extinct = 0, grid_ready = 1.
  - Internal: state IDLE, pending = 0, shadow = 0, active = 0.
- Reset asserted mid-scan blanks the display in the same cycle. Any pending grid is discarded.
- First accept at edge E:
  - grid_ready low during cycle E..E+1.
  - Load into active at E+1; row 0 visible after E+1.
  - grid_ready high after E+1.
- Each row is visible for exactly ROW_HOLD cycles. A frame lasts 8*ROW_HOLD cycles.
- frame_done is high for exactly one cycle, coincident with row 0 of the next frame.
- A grid accepted mid-frame is shown starting at the next frame boundary. Latency is at most 8*ROW_HOLD cycles.
- At most one grid is buffered. The upstream generator must hold grid_valid until it sees grid_ready.

## Test plan
All scenarios use ROW_HOLD = 2.

- **Reset:** reset high, then release, no valid.
  - Response: row_sel = 0, col_data = 0, grid_ready = 1, gen_count = 0, all flags 0, for 20 cycles.
- **Diagonal scan:** accept 64'h8040_2010_0804_0201.
  - Rows 0..7 each show for 2 cycles: row_sel = 8'h01<<r, col_data = 8'h80>>r.
  - frame_done pulses once every 16 cycles.
  - gen_count = 1, extinct = 0, still_life = 0.
- **Backpressure:** during the frame of grid A, accept B (grid_ready falls), then hold C valid.
  - C is not accepted until the cycle after the frame boundary.
  - B is scanned in the next frame, C in the frame after.
  - gen_count = 3.
- **Still life:** accept 64'h0000_1818_0000_0000 twice.
  - Response: still_life = 1, extinct = 0, gen_count = 2.
  - A third, different grid clears still_life.
- **Extinction:** accept 64'h0.
  - Response: extinct = 1; row_sel keeps scanning with col_data = 0.
  - Next nonzero grid clears extinct.
- **Reset mid-scan:** assert reset while row 3 is driven with a grid pending.
  - Response: outputs zero immediately.
  - After release, the block stays in IDLE until a new grid is accepted; the pending grid is never shown.

Source files
------------

// File: rtl/gol_display_scan.sv
// gol_display_scan: double-buffered 8x8 LED matrix scanner for Game of Life
// generations, with generation count and still-life / extinction status.
module gol_display_scan #(
    parameter int unsigned ROW_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid_in,
    input  logic        grid_valid,
    output logic        grid_ready,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic [15:0] gen_count,
    output logic        still_life,
    output logic        extinct
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(ROW_HOLD - 1);

    state_t      state_r;
    state_t      state_s;
    logic [63:0] shadow_r;
    logic [63:0] active_r;
    logic [63:0] active_s;
    logic        pending_r;
    logic [2:0]  row_r;
    logic [2:0]  row_s;
    logic [7:0]  hold_r;
    logic [7:0]  hold_s;
    logic        accept_s;
    logic        swap_s;
    logic        frame_end_s;
    logic [7:0]  row_sel_s;
    logic [7:0]  col_data_s;
    logic [7:0]  row_sel_r;
    logic [7:0]  col_data_r;
    logic        frame_done_r;
    logic [15:0] gen_count_r;
    logic        still_life_r;
    logic        extinct_r;

    // Row r of a grid lives at bits [63-8r -: 8]; {~r, 3'b111} equals 63-8r.
    function automatic logic [7:0] grid_row(input logic [63:0] grid, input logic [2:0] r);
        grid_row = grid[{~r, 3'b111} -: 8];
    endfunction

    assign grid_ready = !pending_r;
    assign accept_s   = grid_valid && !pending_r;
    assign row_sel    = row_sel_r;
    assign col_data   = col_data_r;
    assign frame_done = frame_done_r;
    assign gen_count  = gen_count_r;
    assign still_life = still_life_r;
    assign extinct    = extinct_r;

    // Next scan position, buffer swap decision and next display drive.
    always_comb begin
        state_s     = state_r;
        active_s    = active_r;
        row_s       = row_r;
        hold_s      = hold_r;
        swap_s      = 1'b0;
        frame_end_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pending_r) begin
                    state_s  = SCAN;
                    active_s = shadow_r;
                    row_s    = 3'd0;
                    hold_s   = 8'd0;
                    swap_s   = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            SCAN: begin
                if (hold_r == HOLD_LAST) begin
                    hold_s = 8'd0;
                    row_s  = row_r + 3'd1;
                    if (row_r == 3'd7) begin
                        frame_end_s = 1'b1;
                        // Swap only here so a frame is never torn.
                        if (pending_r) begin
                            active_s = shadow_r;
                            swap_s   = 1'b1;
                        end else begin
                            active_s = active_r;
                        end
                    end else begin
                        frame_end_s = 1'b0;
                    end
                end else begin
                    hold_s = hold_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Drive computed from next state so outputs stay registered yet
        // row 0 appears on the same edge the grid is loaded.
        if (state_s == SCAN) begin
            row_sel_s  = 8'h01 << row_s;
            col_data_s = grid_row(active_s, row_s);
        end else begin
            row_sel_s  = 8'h00;
            col_data_s = 8'h00;
        end
    end

    // Scan state, buffers and pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            shadow_r  <= 64'd0;
            active_r  <= 64'd0;
            pending_r <= 1'b0;
            row_r     <= 3'd0;
            hold_r    <= 8'd0;
        end else begin
            state_r  <= state_s;
            active_r <= active_s;
            row_r    <= row_s;
            hold_r   <= hold_s;
            if (accept_s) begin
                shadow_r  <= grid_in;
                pending_r <= 1'b1;
            end else if (swap_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Generation count and status flags, updated on each accepted grid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_count_r  <= 16'd0;
            still_life_r <= 1'b0;
            extinct_r    <= 1'b0;
        end else if (accept_s) begin
            if (gen_count_r != 16'hFFFF) begin
                gen_count_r <= gen_count_r + 16'd1;
            end
            extinct_r    <= (grid_in == 64'd0);
            still_life_r <= (gen_count_r != 16'd0) && (grid_in == shadow_r);
        end
    end

    // Registered matrix drive and frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_sel_r    <= 8'h00;
            col_data_r   <= 8'h00;
            frame_done_r <= 1'b0;
        end else begin
            row_sel_r    <= row_sel_s;
            col_data_r   <= col_data_s;
            frame_done_r <= frame_end_s;
        end
    end

endmodule

// File: tb/tb_gol_display_scan.sv
// tb_gol_display_scan: directed and randomized checks of gol_display_scan
// against a frame-level reference model (ROW_HOLD = 2).
module tb_gol_display_scan;

    localparam int RH    = 2;
    localparam int FRAME = 8 * RH;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] grid_in = 64'd0;
    logic        grid_valid = 1'b0;
    logic        grid_ready;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    logic [15:0] gen_count;
    logic        still_life;
    logic        extinct;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue holding at most one waiting grid, the grid on
    // show, and the position (cycle number) within the current frame.
    logic [63:0] m_q[$];
    bit          m_scan;
    int          m_t;
    logic [63:0] m_shown;
    int          m_count;
    bit          m_still;
    bit          m_ext;
    logic [63:0] m_last;
    bit          m_fd;
    bit          m_acc;

    gol_display_scan #(.ROW_HOLD(RH)) dut (
        .clk        (clk),
        .reset      (reset),
        .grid_in    (grid_in),
        .grid_valid (grid_valid),
        .grid_ready (grid_ready),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done),
        .gen_count  (gen_count),
        .still_life (still_life),
        .extinct    (extinct)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_scan  = 1'b0;
        m_t     = 0;
        m_shown = 64'd0;
        m_count = 0;
        m_still = 1'b0;
        m_ext   = 1'b0;
        m_last  = 64'd0;
        m_fd    = 1'b0;
        m_acc   = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [63:0] g);
        bit had;
        had   = (m_q.size() != 0);
        m_acc = v && !had;
        m_fd  = 1'b0;
        if (!m_scan) begin
            if (had) begin
                m_scan  = 1'b1;
                m_t     = 0;
                m_shown = m_q.pop_front();
            end
        end else begin
            m_t = (m_t + 1) % FRAME;
            if (m_t == 0) begin
                m_fd = 1'b1;
                if (had) m_shown = m_q.pop_front();
            end
        end
        if (m_acc) begin
            m_still = (m_count != 0) && (g == m_last);
            m_ext   = (g == 64'd0);
            m_last  = g;
            if (m_count < 65535) m_count++;
            m_q.push_back(g);
        end
    endtask

    task automatic check_all();
        logic [7:0] ers;
        logic [7:0] ecd;
        int r;
        r = m_t / RH;
        if (m_scan) begin
            ers = 8'h01 << r;
            ecd = 8'(m_shown >> (8 * (7 - r)));
        end else begin
            ers = 8'h00;
            ecd = 8'h00;
        end
        chk("row_sel",    64'(row_sel),    64'(ers));
        chk("col_data",   64'(col_data),   64'(ecd));
        chk("frame_done", 64'(frame_done), 64'(m_fd));
        chk("grid_ready", 64'(grid_ready), 64'(m_q.size() == 0));
        chk("gen_count",  64'(gen_count),  64'(m_count));
        chk("still_life", 64'(still_life), 64'(m_still));
        chk("extinct",    64'(extinct),    64'(m_ext));
    endtask

    // One clock: capture inputs, advance model, check #1 after the edge.
    task automatic cycle();
        logic v;
        logic [63:0] g;
        logic rs;
        v  = grid_valid;
        g  = grid_in;
        rs = reset;
        @(posedge clk);
        if (rs) model_reset();
        else model_edge(v, g);
        #1;
        check_all();
    endtask

    task automatic send(input logic [63:0] g);
        int n;
        n          = 0;
        grid_valid = 1'b1;
        grid_in    = g;
        m_acc      = 1'b0;
        while (!m_acc && n < 200) begin
            cycle();
            n++;
        end
        chk("send_accepted", 64'(m_acc), 64'd1);
        grid_valid = 1'b0;
    endtask

    // Assert reset between edges, check immediate blanking, release.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] ga;
        logic [63:0] gs;
        logic [63:0] last_g;
        logic [7:0]  lr;
        logic [7:0]  lc;
        bit          holding;
        int          n;

        model_reset();
        repeat (3) cycle();
        reset = 1'b0;

        // Reset: idle and blank for 20 cycles
        repeat (20) cycle();

        // Diagonal scan with explicit row/column expectations
        send(64'h8040_2010_0804_0201);
        cycle();
        for (int r = 0; r < 8; r++) begin
            for (int h = 0; h < RH; h++) begin
                lr = 8'h01 << r;
                lc = 8'h80 >> r;
                chk("diag_row_sel",  64'(row_sel),  64'(lr));
                chk("diag_col_data", 64'(col_data), 64'(lc));
                chk("diag_no_fd",    64'(frame_done), 64'd0);
                cycle();
            end
        end
        chk("diag_frame_done", 64'(frame_done), 64'd1);
        chk("diag_gen_count",  64'(gen_count),  64'd1);
        chk("diag_extinct",    64'(extinct),    64'd0);
        chk("diag_still",      64'(still_life), 64'd0);
        repeat (2 * FRAME) cycle();

        // Backpressure: A, then B mid-frame, then C held until boundary
        do_reset();
        ga = {$urandom, $urandom} | 64'h1;
        send(ga);
        send(ga ^ 64'hFFFF_0000_FFFF_0000);
        send(ga ^ 64'h00FF_00FF_00FF_00FF);
        chk("bp_gen_count", 64'(gen_count), 64'd3);
        repeat (3 * FRAME) cycle();

        // Still life
        do_reset();
        gs = 64'h0000_1818_0000_0000;
        send(gs);
        send(gs);
        chk("still_set",   64'(still_life), 64'd1);
        chk("still_ext",   64'(extinct),    64'd0);
        chk("still_count", 64'(gen_count),  64'd2);
        send(gs ^ 64'h0000_0000_0000_0100);
        chk("still_clear", 64'(still_life), 64'd0);

        // Extinction
        send(64'h0);
        chk("ext_set", 64'(extinct), 64'd1);
        repeat (2 * FRAME + 4) cycle();
        send(64'h0000_0018_2400_0000);
        chk("ext_clear", 64'(extinct), 64'd0);
        repeat (2 * FRAME) cycle();

        // Reset mid-scan at row 3 with a grid pending
        do_reset();
        send(64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        send(64'hAAAA_5555_AAAA_5555);
        n = 0;
        while (m_t != 3 * RH && n < 100) begin
            cycle();
            n++;
        end
        chk("mid_row3", 64'(row_sel), 64'h08);
        do_reset();
        chk("mid_blank_row", 64'(row_sel),  64'd0);
        chk("mid_blank_col", 64'(col_data), 64'd0);
        repeat (3 * FRAME) cycle();
        chk("mid_idle", 64'(row_sel), 64'd0);

        // Randomized traffic against the model
        last_g  = 64'd0;
        holding = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!holding && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: grid_in = {$urandom, $urandom};
                    1: grid_in = last_g;
                    2: grid_in = 64'h0;
                    default: grid_in = 64'h1 << $urandom_range(0, 63);
                endcase
                grid_valid = 1'b1;
                holding    = 1'b1;
            end
            cycle();
            if (holding && m_acc) begin
                holding    = 1'b0;
                grid_valid = 1'b0;
                last_g     = grid_in;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
